acc_sched: RTL
==============

# acc_sched

Round-robin scheduler that shares one 32-bit accumulate datapath among several requesters. Each requester presents an operand and holds a request. The block arbitrates, runs the three-state load/accumulate sequence on the shared accumulator, and returns a one-cycle grant as acknowledge. It sits between the requesting front-end blocks and the shared accumulator/LED status logic.

## Interface
- NREQ, 4, number of requesters; power of two, 2..8
- W, 32, operand and accumulator width
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request level
- req_value  input  NREQ*W  operands; requester i occupies bits [i*W +: W]
- clear  input  1  synchronous accumulator clear request
- gnt  output  NREQ  one-hot acknowledge, high for exactly one cycle per serviced request
- busy  output  1  high whenever the FSM is not in IDLE
- owner  output  clog2(NREQ)  index of the requester being serviced or last serviced
- acc  output  W  accumulator value
- ovf  output  1  sticky carry-out flag
- led  output  8  acc[7:0] masked by busy: acc[7:0] & {8{~busy}}

## Operation
- FSM states: IDLE, LOAD, ACCUM. Encoding is free.
- IDLE
  - clear=1: acc<=0, ovf<=0, state stays IDLE. Clear wins over any pending req.
  - else if |req: winner = first asserted req found scanning from ptr upward, modulo NREQ. owner<=winner, opnd<=req_value[winner], state<=LOAD.
- LOAD: state<=ACCUM. The operand is already captured, so requester changes have no effect.
- ACCUM
  - acc <= (acc + opnd) mod 2^W.
  - ovf <= ovf | carry-out.
  - ptr <= (owner+1) mod NREQ.
  - state<=IDLE.
- clear outside IDLE is ignored, not deferred. The requester must hold clear until busy=0.
- gnt is combinational from registered state: gnt = onehot(owner) while state==ACCUM, else 0.
- Requester protocol
  - Raise req and keep req_value stable until gnt[i] is sampled high.
  - Drop req on the edge after gnt, or keep req high to queue another operation.
  - Dropping req after capture (in LOAD/ACCUM) does not cancel the operation.
- busy = (state != IDLE).
- Reset values: state=IDLE, acc=0, ovf=0, ptr=0, owner=0, opnd=0, gnt=0, busy=0, led=0.

## Timing
- Edge 0: req sampled in IDLE.
- Cycle 1: LOAD; busy=1.
- Cycle 2: ACCUM; gnt[owner]=1.
- Edge 3: new acc is visible; FSM is back in IDLE.
- Request-to-acc latency is 3 cycles. Peak throughput is one operation per 3 cycles.
- With req still high after edge 3, the next arbitration happens in that IDLE cycle. There are no dead cycles beyond IDLE.
- Fairness: with all requesters continuously asserted, each is granted exactly once per NREQ operations.
- Asynchronous reset mid-LOAD/ACCUM aborts the operation: no gnt, acc=0. The FSM restarts in IDLE after RST_N rises, and arbitration resumes from ptr=0.
- Add wraps silently. ovf stays set until clear or reset.

## Test plan
- Single request:
  - Stimulus: after reset, req=0001, req_value[0]=5.
  - Required: busy high for 2 cycles, gnt=0001 in the third cycle, acc=5 the cycle after, owner=0, led=0x05 once busy=0.
- Simultaneous requests:
  - Stimulus: req=0110 with values 10 (req1) and 20 (req2), both held until their gnt.
  - Required: gnt order 0010 then 0100, 3 cycles apart; final acc=30.
- Round robin:
  - Stimulus: req=1111 held for 15 cycles.
  - Required: grants 0,1,2,3,0 in that order; gnt never has more than one bit set.
- Overflow:
  - Stimulus: req0 value 0xFFFFFFF0, then req0 value 0x20.
  - Required: acc=0x00000010 and ovf=1. A following clear in IDLE gives acc=0, ovf=0.
- Clear vs request, and clear while busy:
  - Stimulus: assert clear and req0 together in IDLE, then assert clear for one cycle during LOAD.
  - Required: the first clear wins (acc=0, no LOAD that cycle) and req0 is serviced next cycle. The clear during LOAD is ignored (acc still updated).
- Reset mid-operation:
  - Stimulus: drive RST_N low during ACCUM.
  - Required: gnt, busy and acc drop to 0 immediately (asynchronously). After release with req=0100, the first grant is to requester 2 and acc equals its value.

Source files
------------

// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler sharing one W-bit accumulate datapath
// among NREQ requesters. Each accepted request runs IDLE -> LOAD -> ACCUM
// and is acknowledged by a one-cycle grant while the FSM is in ACCUM.
//
// Handshake: requester i holds req[i] high with req_value[i] stable. The
// request counts as accepted on the rising edge where the FSM is in IDLE and
// i wins arbitration. gnt[i] is high for exactly one cycle (ACCUM) per
// accepted request, and req[i] may drop on the edge that follows. A request
// still high after that edge is arbitrated again in the next IDLE cycle.
module acc_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_value,
    input  logic              clear,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic [IW-1:0]     owner,
    output logic [W-1:0]      acc,
    output logic              ovf,
    output logic [7:0]        led,
    output logic [1:0]        state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;

    logic [IW-1:0] ptr;
    logic [W-1:0]  opnd;
    logic [IW-1:0] winner;
    logic          found;
    logic [W-1:0]  vals [NREQ];
    logic [W:0]    sum;

    // Split the flat operand bus into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            vals[i] = req_value[i*W +: W];
        end
    end

    // Rotating priority: first asserted request at or above ptr, wrapping.
    // NREQ is a power of two, so the IW-bit addition wraps modulo NREQ.
    always_comb begin
        logic [IW-1:0] idx;
        winner = ptr;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + k[IW-1:0];
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Widened add so the carry-out can feed the sticky overflow flag.
    assign sum = {1'b0, acc} + {1'b0, opnd};

    // Scheduler FSM and accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            ptr   <= '0;
            owner <= '0;
            opnd  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Clear has priority over any pending request.
                    if (clear) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end else if (found) begin
                        owner <= winner;
                        opnd  <= vals[winner];
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Operand already captured; requester changes are ignored.
                    state <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc   <= sum[W-1:0];
                    ovf   <= ovf | sum[W];
                    ptr   <= owner + 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Grant is the one-hot owner while accumulating.
    always_comb begin
        gnt = '0;
        if (state == S_ACCUM) begin
            gnt[owner] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);
    assign led  = acc[7:0] & {8{~busy}};

endmodule
